persiana_motor_driver: RTL and testbench

//  Output stage placed directly after the blind controller's Mealy motor FSM.

---
 rtl/persiana_motor_driver.sv | 120 ++++++++++++
 tb/tb_persiana_motor_driver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/persiana_motor_driver.sv
// Relay output stage for the blind controller: interlocked up/down enables,
// dead time between runs, end-switch cutoff and a latched run-timeout fault.
// Optional short-circuit brake output "freno" when PERSIANA_BRAKE_EN is defined.
module persiana_motor_driver #(
  parameter int DEAD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic Reloj,
  input  logic reset,
  input  logic subir,
  input  logic bajar,
  input  logic Ssup,
  input  logic Sinf,
  output logic motor_up,
  output logic motor_down,
  output logic busy,
  output logic fault
`ifdef PERSIANA_BRAKE_EN
  ,
  output logic freno
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_UP   = 3'd1,
    RUN_DOWN = 3'd2,
    DEAD     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0] dead_cnt_reg, dead_cnt_next;

  logic req_up, req_dn;

  // Simultaneous subir/bajar is a stop request, so neither direction is valid.
  assign req_up = subir & ~bajar & ~Ssup;
  assign req_dn = bajar & ~subir & ~Sinf;

  always_comb begin
    state_next    = state_reg;
    run_cnt_next  = run_cnt_reg;
    dead_cnt_next = dead_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_up) begin
          state_next   = RUN_UP;
          run_cnt_next = '0;
        end else if (req_dn) begin
          state_next   = RUN_DOWN;
          run_cnt_next = '0;
        end
      end
      RUN_UP: begin
        if (!req_up) begin
          state_next    = DEAD;
          dead_cnt_next = DEAD_LOAD;
        end else if (run_cnt_reg == RUN_LAST) begin
          state_next = FAULT;
        end else begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end
      end
      RUN_DOWN: begin
        if (!req_dn) begin
          state_next    = DEAD;
          dead_cnt_next = DEAD_LOAD;
        end else if (run_cnt_reg == RUN_LAST) begin
          state_next = FAULT;
        end else begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end
      end
      DEAD: begin
        // Always drains back to IDLE, so a reversal can never skip the gap.
        if (dead_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          dead_cnt_next = dead_cnt_reg - 1'b1;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so they track state_reg.
  always_ff @(posedge Reloj) begin
    if (reset) begin
      state_reg    <= IDLE;
      run_cnt_reg  <= '0;
      dead_cnt_reg <= '0;
      motor_up     <= 1'b0;
      motor_down   <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
`ifdef PERSIANA_BRAKE_EN
      freno        <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      run_cnt_reg  <= run_cnt_next;
      dead_cnt_reg <= dead_cnt_next;
      motor_up     <= (state_next == RUN_UP);
      motor_down   <= (state_next == RUN_DOWN);
      busy         <= (state_next != IDLE);
      fault        <= (state_next == FAULT);
`ifdef PERSIANA_BRAKE_EN
      freno        <= (state_next == DEAD);
`endif
    end
  end

endmodule

// File: tb/tb_persiana_motor_driver.sv
// Bench for persiana_motor_driver: directed scenarios plus random segments,
// checked every cycle against a behavioural run/cooldown/fault model.
module tb_persiana_motor_driver;

  localparam int DEAD = 4;
  localparam int TMO  = 20;

  logic clk = 1'b0;
  logic reset, subir, bajar, Ssup, Sinf;
  logic motor_up, motor_down, busy, fault;
`ifdef PERSIANA_BRAKE_EN
  logic freno;
`endif

  always #5 clk = ~clk;

  persiana_motor_driver #(
    .DEAD_CYCLES(DEAD),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(16)
  ) dut (
    .Reloj(clk),
    .reset(reset),
    .subir(subir),
    .bajar(bajar),
    .Ssup(Ssup),
    .Sinf(Sinf),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .busy(busy),
    .fault(fault)
`ifdef PERSIANA_BRAKE_EN
    ,
    .freno(freno)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  // Model: direction of travel, cycles already run, cooldown left, latched fault.
  int dir_m = 0;
  int run_m = 0;
  int cool_m = 0;
  bit flt_m = 1'b0;
  int up_cycles = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit up_ok, dn_ok;
    up_ok = subir && !bajar && !Ssup;
    dn_ok = bajar && !subir && !Sinf;
    if (reset) begin
      dir_m = 0; run_m = 0; cool_m = 0; flt_m = 1'b0;
    end else if (flt_m) begin
      // latched until reset
    end else if (cool_m > 0) begin
      cool_m--;
    end else if (dir_m == 0) begin
      if (up_ok) begin dir_m = 1; run_m = 1; end
      else if (dn_ok) begin dir_m = -1; run_m = 1; end
    end else begin
      if ((dir_m == 1 && !up_ok) || (dir_m == -1 && !dn_ok)) begin
        dir_m = 0; cool_m = DEAD;
      end else if (run_m == TMO) begin
        dir_m = 0; flt_m = 1'b1;
      end else begin
        run_m++;
      end
    end
  endtask

  // Apply inputs at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic s, input logic b, input logic su, input logic si, input logic rs);
    subir = s; bajar = b; Ssup = su; Sinf = si; reset = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (motor_up === 1'b1) up_cycles++;
    chk("motor_up", motor_up, dir_m == 1);
    chk("motor_down", motor_down, dir_m == -1);
    chk("busy", busy, (dir_m != 0) || (cool_m > 0) || flt_m);
    chk("fault", fault, flt_m);
    chk("interlock", motor_up & motor_down, 1'b0);
`ifdef PERSIANA_BRAKE_EN
    chk("freno", freno, (cool_m > 0) && !flt_m);
`endif
  endtask

  task automatic hold(input int n, input logic s, input logic b, input logic su, input logic si);
    for (int i = 0; i < n; i++) step(s, b, su, si, 1'b0);
  endtask

  initial begin
    subir = 0; bajar = 0; Ssup = 0; Sinf = 0; reset = 1;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_up", motor_up, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_fault", fault, 1'b0);

    // 1: ten cycles of subir, then dead time back to idle
    up_cycles = 0;
    hold(10, 1, 0, 0, 0);
    hold(6, 0, 0, 0, 0);
    chk_int("t1_up_cycles", up_cycles, 10);
    chk("t1_idle_busy", busy, 1'b0);

    // 2: end switches stop and block runs
    hold(3, 1, 0, 0, 0);
    hold(8, 1, 0, 1, 0);
    chk("t2_ssup_blocks", motor_up, 1'b0);
    hold(3, 0, 0, 0, 0);
    hold(3, 0, 1, 0, 0);
    hold(8, 0, 1, 0, 1);
    chk("t2_sinf_blocks", motor_down, 1'b0);
    hold(6, 0, 0, 0, 0);

    // 3: reversal passes through dead time and idle
    hold(4, 1, 0, 0, 0);
    hold(10, 0, 1, 0, 0);
    hold(8, 0, 0, 0, 0);

    // 4: timeout fault, then requests ignored until reset
    step(0, 0, 0, 0, 1);
    up_cycles = 0;
    hold(30, 1, 0, 0, 0);
    chk_int("t4_up_cycles", up_cycles, TMO);
    chk("t4_fault", fault, 1'b1);
    hold(5, 0, 1, 0, 0);
    chk("t4_fault_hold", fault, 1'b1);
    step(0, 0, 0, 0, 1);
    chk("t4_fault_clear", fault, 1'b0);

    // 5: stop request, stop mid-run, reset mid-run
    hold(3, 1, 1, 0, 0);
    chk("t5_both_idle", busy, 1'b0);
    hold(3, 0, 1, 0, 0);
    hold(2, 1, 1, 0, 0);
    hold(6, 0, 0, 0, 0);
    hold(3, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1);
    chk("t5_reset_down", motor_down, 1'b0);
    hold(2, 0, 0, 0, 0);

    // Random segments of held inputs with occasional reset
    for (int k = 0; k < 120; k++) begin
      logic s, b, su, si;
      int n;
      s  = ($urandom_range(0, 99) < 55);
      b  = ($urandom_range(0, 99) < 45);
      su = ($urandom_range(0, 99) < 20);
      si = ($urandom_range(0, 99) < 20);
      n  = $urandom_range(1, 26);
      if ($urandom_range(0, 99) < 5) step(s, b, su, si, 1'b1);
      hold(n, s, b, su, si);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
